// File: rtl/l2b_sio_pkg.sv
// Shared definitions for the L2-bank -> SIO response path.
//   rsp_type_e : response type encoding carried in the header TYPE field
//   header map : CTAG [15:0], TYPE [17:16], upper bits zero
//   par16x2()  : even parity per 16-bit half, [1] = data[31:16], [0] = data[15:0]
package l2b_sio_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CTAG_W   = 16;
    localparam int unsigned TYPE_W   = 2;
    localparam int unsigned CTAG_LSB = 0;
    localparam int unsigned TYPE_LSB = 16;
    localparam int unsigned BEATS    = 16;
    localparam int unsigned BEAT_W   = 4;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        RSP_RD  = 2'b00,
        RSP_WR8 = 2'b01,
        RSP_WRI = 2'b10,
        RSP_RSV = 2'b11
    } rsp_type_e;

    // Even parity: each bit makes its half plus the bit carry an even number of ones.
    function automatic logic [1:0] par16x2(input logic [DATA_W-1:0] word);
        return {^word[31:16], ^word[15:0]};
    endfunction

endpackage

// File: rtl/l2b_sio_credit_cnt.sv
// Saturating SIO credit counter with sticky overflow flag.
//   clk, rst        : clock, synchronous active-high reset (restores CREDITS)
//   take            : a response was accepted this cycle (consumes a credit)
//   give            : SIO returned a credit this cycle
//   credit_avail_c  : combinational, at least one credit held
//   credit_ovf      : registered, sticky; credit returned while already full
module l2b_sio_credit_cnt
    import l2b_sio_pkg::*;
#(
    parameter int unsigned CREDITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic take,
    input  logic give,
    output logic credit_avail_c,
    output logic credit_ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // A take and a give in the same cycle cancel; a give at full saturates and flags.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (take && !give) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (give && !take) begin
            if (cnt_q == CNT_W'(CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_W'(CREDITS);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign credit_avail_c = (cnt_q != '0);
    assign credit_ovf     = ovf_q;

endmodule

// File: rtl/l2b_sio_resp_tx.sv
// L2-bank transmitter for outbound SIO responses: one header cycle, plus
// 16 data beats from the local line buffer for reads, gated by SIO credits.
//   iol2clk, rst         : clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data : line-buffer write port (honoured only while idle)
//   cmd_*                : response command handshake (cmd_rdy combinational)
//   sio_l2b_credit       : credit-return pulse from SIO
//   l2b_sio_*            : registered header/data stream with parity and UE
//   credit_ovf           : sticky credit overflow error
module l2b_sio_resp_tx
    import l2b_sio_pkg::*;
#(
    parameter int unsigned CREDITS = 2
) (
    input  logic              iol2clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [1:0]        cmd_type,
    input  logic [CTAG_W-1:0] cmd_ctag,
    input  logic              cmd_ue,
    input  logic              sio_l2b_credit,
    output logic              l2b_sio_ctag_vld,
    output logic [DATA_W-1:0] l2b_sio_data,
    output logic [1:0]        l2b_sio_parity,
    output logic              l2b_sio_ue_err,
    output logic              credit_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    rsp_type_e         type_q, type_d;
    logic              ctag_vld_q, ctag_vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        parity_q, parity_d;
    logic              ue_err_q, ue_err_d;
    logic [DATA_W-1:0] mem_q [BEATS];
    logic              credit_avail_c;
    logic              accept_c;

    assign cmd_rdy  = (state_q == ST_IDLE) && credit_avail_c;
    assign accept_c = cmd_vld && cmd_rdy;

    l2b_sio_credit_cnt #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk            (iol2clk),
        .rst            (rst),
        .take           (accept_c),
        .give           (sio_l2b_credit),
        .credit_avail_c (credit_avail_c),
        .credit_ovf     (credit_ovf)
    );

    // Outputs are computed for the state being entered so they launch from flops
    // in the same cycle the FSM occupies that state; ctag and ue live only in the
    // header register since nothing after the header needs them.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        type_d     = type_q;
        ctag_vld_d = 1'b0;
        data_d     = '0;
        ue_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d    = ST_HDR;
                    type_d     = rsp_type_e'(cmd_type);
                    ctag_vld_d = 1'b1;
                    data_d[CTAG_LSB +: CTAG_W] = cmd_ctag;
                    data_d[TYPE_LSB +: TYPE_W] = cmd_type;
                    ue_err_d   = cmd_ue && (rsp_type_e'(cmd_type) == RSP_RD);
                end
            end
            ST_HDR: begin
                if (type_q == RSP_RD) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                    data_d  = mem_q[0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                    data_d = mem_q[beat_q + BEAT_W'(1)];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        parity_d = par16x2(data_d);
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            type_q     <= RSP_RD;
            ctag_vld_q <= 1'b0;
            data_q     <= '0;
            parity_q   <= '0;
            ue_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            type_q     <= type_d;
            ctag_vld_q <= ctag_vld_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            ue_err_q   <= ue_err_d;
        end
    end

    // Line buffer, not reset; writes outside IDLE are dropped so a streaming
    // read always sees a stable line.
    always_ff @(posedge iol2clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign l2b_sio_ctag_vld = ctag_vld_q;
    assign l2b_sio_data     = data_q;
    assign l2b_sio_parity   = parity_q;
    assign l2b_sio_ue_err   = ue_err_q;

endmodule

// File: tb/tb_l2b_sio_resp_tx.sv
// Scoreboard bench for l2b_sio_resp_tx: a driver runs a queue-based response
// model and pushes the expected per-cycle outputs; a monitor pops and compares.
module tb_l2b_sio_resp_tx;

    localparam int unsigned CREDITS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_type = '0;
    logic [15:0] cmd_ctag = '0;
    logic        cmd_ue = 1'b0;
    logic        sio_l2b_credit = 1'b0;
    logic        l2b_sio_ctag_vld;
    logic [31:0] l2b_sio_data;
    logic [1:0]  l2b_sio_parity;
    logic        l2b_sio_ue_err;
    logic        credit_ovf;

    always #5 clk = ~clk;

    l2b_sio_resp_tx #(.CREDITS(CREDITS)) dut (
        .iol2clk          (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_idx           (wr_idx),
        .wr_data          (wr_data),
        .cmd_vld          (cmd_vld),
        .cmd_rdy          (cmd_rdy),
        .cmd_type         (cmd_type),
        .cmd_ctag         (cmd_ctag),
        .cmd_ue           (cmd_ue),
        .sio_l2b_credit   (sio_l2b_credit),
        .l2b_sio_ctag_vld (l2b_sio_ctag_vld),
        .l2b_sio_data     (l2b_sio_data),
        .l2b_sio_parity   (l2b_sio_parity),
        .l2b_sio_ue_err   (l2b_sio_ue_err),
        .credit_ovf       (credit_ovf)
    );

    typedef struct packed {
        logic        vld;
        logic [31:0] data;
        logic [1:0]  par;
        logic        ue;
        logic        rdy;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];     // expected DUT view after each clock edge
    exp_t        pend[$];     // words the model still has to send
    logic [31:0] mbuf [16];
    int          mcred;
    bit          movf;
    bit          midle;
    bit          mrdy;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [1:0] mpar(input logic [31:0] w);
        logic hi, lo;
        hi = 1'($countones(w[31:16]) % 2);
        lo = 1'($countones(w[15:0]) % 2);
        return {hi, lo};
    endfunction

    function automatic exp_t mk_word(input bit v, input logic [31:0] d, input bit ue);
        exp_t e;
        e.vld  = v;
        e.data = d;
        e.par  = mpar(d);
        e.ue   = ue;
        e.rdy  = 1'b0;
        e.ovf  = 1'b0;
        return e;
    endfunction

    // One cycle: drive inputs for the next edge and predict what follows it.
    task automatic step(input bit vld, input logic [1:0] ty, input logic [15:0] ct,
                        input bit ue, input bit wen, input logic [3:0] idx,
                        input logic [31:0] wd, input bit cred, input bit r,
                        output bit acc);
        exp_t e;
        cmd_vld = vld; cmd_type = ty; cmd_ctag = ct; cmd_ue = ue;
        wr_en = wen; wr_idx = idx; wr_data = wd;
        sio_l2b_credit = cred; rst = r;
        acc = vld && mrdy && !r;
        if (r) begin
            pend.delete();
            mcred = CREDITS;
            movf  = 1'b0;
            e     = mk_word(1'b0, 32'h0, 1'b0);
            midle = 1'b1;
        end else begin
            if (wen && midle) mbuf[idx] = wd;
            if (acc && !cred)       mcred--;
            else if (cred && !acc) begin
                if (mcred == CREDITS) movf = 1'b1;
                else                  mcred++;
            end
            if (acc) begin
                pend.push_back(mk_word(1'b1, {14'b0, ty, ct}, ue && (ty == 2'b00)));
                if (ty == 2'b00)
                    for (int i = 0; i < 16; i++) pend.push_back(mk_word(1'b0, mbuf[i], 1'b0));
            end
            if (pend.size() > 0) begin
                e = pend.pop_front();
                midle = 1'b0;
            end else begin
                e = mk_word(1'b0, 32'h0, 1'b0);
                midle = 1'b1;
            end
        end
        mrdy  = midle && (mcred != 0);
        e.rdy = mrdy;
        e.ovf = movf;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit cred);
        bit a;
        for (int i = 0; i < n; i++) step(0, 2'b00, 16'h0, 0, 0, 4'h0, 32'h0, cred, 0, a);
    endtask

    task automatic send(input logic [1:0] ty, input logic [15:0] ct, input bit ue, input bit cred_on_acc);
        bit a = 1'b0;
        int n = 0;
        while (!a && n < 60) begin
            step(1, ty, ct, ue, 0, 4'h0, 32'h0, cred_on_acc && mrdy, 0, a);
            n++;
        end
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: command type %0d ctag %h not accepted within 60 cycles", ty, ct);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: one expected entry per edge once the driver is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ctag_vld", 32'(l2b_sio_ctag_vld), 32'(e.vld));
                chk("data",     l2b_sio_data,          e.data);
                chk("parity",   32'(l2b_sio_parity),   32'(e.par));
                chk("ue_err",   32'(l2b_sio_ue_err),   32'(e.ue));
                chk("cmd_rdy",  32'(cmd_rdy),          32'(e.rdy));
                chk("credit_ovf", 32'(credit_ovf),     32'(e.ovf));
            end
        end
    end

    initial begin
        bit a;
        mcred = CREDITS; movf = 0; midle = 1; mrdy = (CREDITS != 0);
        for (int i = 0; i < 16; i++) mbuf[i] = 32'h0;
        @(negedge clk);

        // reset
        step(0, 2'b00, 16'h0, 0, 0, 4'h0, 32'h0, 0, 1, a);
        step(0, 2'b00, 16'h0, 0, 0, 4'h0, 32'h0, 1, 1, a);

        // fill the line, then one read
        for (int i = 0; i < 16; i++)
            step(0, 2'b00, 16'h0, 0, 1, 4'(i), 32'h1000_0000 + 32'(i), 0, 0, a);
        send(2'b00, 16'h00A5, 0, 0);
        idle(18, 0);
        idle(1, 1);

        // back-to-back write acks exhaust credits
        send(2'b01, 16'hFFFF, 0, 0);
        send(2'b10, 16'h0001, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 2'b01, 16'h0333, 0, 0, 4'h0, 32'h0, 0, 0, a);
        step(1, 2'b01, 16'h0333, 0, 0, 4'h0, 32'h0, 1, 0, a);
        send(2'b01, 16'h0333, 0, 0);
        idle(2, 0);
        idle(2, 1);

        // overflow at full, then accept coinciding with a credit
        idle(1, 1);
        idle(2, 0);
        send(2'b01, 16'h1234, 0, 1);
        idle(1, 0);
        send(2'b11, 16'h4321, 1, 0);
        send(2'b01, 16'h5678, 0, 0);
        idle(3, 0);

        // read with UE, dropped buffer write, reset mid-stream
        step(0, 2'b00, 16'h0, 0, 0, 4'h0, 32'h0, 0, 1, a);
        send(2'b00, 16'h0BAD, 1, 0);
        idle(1, 0);
        step(0, 2'b00, 16'h0, 0, 1, 4'h3, 32'hDEAD_BEEF, 0, 0, a);
        idle(6, 0);
        step(0, 2'b00, 16'h0, 0, 0, 4'h0, 32'h0, 0, 1, a);
        idle(3, 0);
        send(2'b00, 16'h0C0C, 0, 0);
        idle(18, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, w;
            r = ($urandom % 80) == 0;
            w = !r && (($urandom % 4) == 0);
            step(1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom), w,
                 4'($urandom), $urandom, ($urandom % 6) == 0, r, a);
        end

        idle(20, 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
